demux1to16_deser: RTL and testbench
===================================

# demux1to16_deser

Serial-to-parallel 1:16 demultiplexer: the receive-side counterpart of the 16:1 bit-select mux. A 4-bit position counter steers each accepted serial bit into slot `dout[cnt]`, which is the inverse of `out = in[sel]` with `sel` stepping 0..15. Completed 16-bit words are presented on a registered output with a valid/ready handshake. The block sits between a serial link front-end and word-wide consumers in the same clock domain.

## Interface
Parameters:
- `WIDTH`, 16: word width; must equal 2**`SEL_W`.
- `SEL_W`, 4: position counter width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  1  serial data bit.
- `din_valid`  in  1  `din` is accepted on this edge.
- `sof`  in  1  start of frame; qualified by `din_valid`; marks the current bit as position 0.
- `dout`  out  WIDTH  assembled word; bit k = k-th bit of the frame.
- `dout_valid`  out  1  `dout` holds an unconsumed word.
- `dout_ready`  in  1  consumer accepts `dout` when high with `dout_valid`.
- `sel_cnt`  out  SEL_W  slot the next accepted bit will be written to.
- `frame_err`  out  1  one-cycle pulse: `sof` arrived with `sel_cnt != 0`.
- `overrun`  out  1  sticky: a word completed while the output was still occupied.

## Operation
- Shadow register `shreg[WIDTH-1:0]` and counter `cnt` (driven on `sel_cnt`).
- Accepted bit (`din_valid`=1):
  - Without `sof`: `shreg[cnt] <= din`, then `cnt <= cnt+1`, wrapping 15 -> 0.
  - With `sof`: `shreg[0] <= din`, then `cnt <= 1`. The partial frame is discarded and never output.
  - `frame_err` pulses if `cnt` was not 0. `sof` at `cnt==0` is legal and produces no pulse.
- Word completion: an accepted bit written to slot 15 (no `sof`) completes the word.
  - The completed word is `{din, shreg[14:0]}`.
  - If the output slot is free, the word loads into `dout` and `dout_valid <= 1`.
  - The output slot is free when `dout_valid`=0, or when `dout_valid`=1 and `dout_ready`=1 in the same cycle.
  - If the slot is not free, the new word is dropped, `dout` is unchanged and `overrun <= 1`.
- Handshake: a transfer occurs on any edge where `dout_valid` and `dout_ready` are both 1. Without a simultaneous load, `dout_valid <= 0`. `dout` is stable while `dout_valid`=1 and `dout_ready`=0.
- `din_valid`=0: counter and shadow register hold; `din` and `sof` are ignored.
- `overrun` clears only on reset.
- Arithmetic: `cnt` is modulo 2**`SEL_W`; no saturation.

## Timing
- Reset values (edge with `rst_n`=0): `dout`=0, `dout_valid`=0, `sel_cnt`=0, `frame_err`=0, `overrun`=0, `shreg`=0.
- Reset mid-frame drops the partial word. Reset also overrides a completion in the same cycle.
- Latency: `dout_valid` is high in the cycle after the edge that accepted bit 15. This is 1 cycle after the last bit, and 16 accepted bits after `sof`.
- `frame_err` is high for exactly the cycle after the offending `sof` edge.
- Back-to-back frames: the next bit after bit 15 may arrive on the immediately following edge. It is written to slot 0 with no bubble.
- Simultaneous completion and transfer: `dout_valid` stays 1, `dout` takes the new word, and `overrun` is unchanged.
- Full throughput is one word per 16 cycles with `dout_ready` tied high.

## Test plan
- Reset, then shift 16'h30FA LSB-first with `sof` on the first bit and `din_valid`=1 for 16 cycles, `dout_ready`=0. Required: `dout`=16'h30FA, `dout_valid`=1 in cycle 17 and held, `sel_cnt`=0, no `frame_err`.
- Apply 16'hA5C3 with `din_valid` toggling 1/0 every cycle and `dout_ready`=1. Required: word appears after the 16th accepted bit, not after 16 cycles. `dout_valid` is high for one cycle only.
- Send 5 bits, then assert `sof` and send a full frame of 16'h0001. Required: `frame_err` pulses once, and the single output word is 16'h0001.
- Send two back-to-back frames, 16'h1234 then 16'hFFFF, with `dout_ready`=0. Required: `dout` stays 16'h1234 and `overrun`=1. Then raise `dout_ready`: `dout_valid` falls and `overrun` stays 1.
- Send two back-to-back frames with `dout_ready` pulsed high on the completion edge of the second. Required: `dout` 16'h1234 then 16'hBEEF, `dout_valid` continuously 1, and `overrun`=0.
- Send 10 bits, drop `rst_n` for one cycle, then send a full frame of 16'h00FF. Required: every output is 0 after reset, and the only word produced is 16'h00FF.

Source files
------------

// File: rtl/demux1to16_deser_if.sv
// demux1to16_deser_if: serial-in / word-out bundle for the 1:16 deserializer
interface demux1to16_deser_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic din;
  logic din_valid;
  logic sof;
  logic [WIDTH-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic [SEL_W-1:0] sel_cnt;
  logic frame_err;
  logic overrun;
  modport master (
    output din, din_valid, sof, dout_ready,
    input  dout, dout_valid, sel_cnt, frame_err, overrun
  );
  modport slave (
    input  din, din_valid, sof, dout_ready,
    output dout, dout_valid, sel_cnt, frame_err, overrun
  );
endinterface

// File: rtl/demux1to16_deser.sv
// demux1to16_deser: steers serial bits into slot cnt, presents completed words with valid/ready
module demux1to16_deser #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input logic clk,
  input logic rst_n,
  demux1to16_deser_if.slave bus
);
  logic [WIDTH-1:0] shreg, dout, word;
  logic [SEL_W-1:0] cnt;
  logic dout_valid, frame_err, overrun, done, slot_free;
  always_comb begin
    done = bus.din_valid && !bus.sof && (cnt == '1);
    slot_free = !dout_valid || bus.dout_ready;
    word = {bus.din, shreg[WIDTH-2:0]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= bus.din_valid && bus.sof && (cnt != '0);
      if (bus.din_valid) begin
        if (bus.sof) begin
          shreg[0] <= bus.din;
          cnt <= SEL_W'(1);
        end else begin
          shreg[cnt] <= bus.din;
          cnt <= cnt + 1'b1;
        end
      end
      // a completion into an occupied slot is dropped and latched as overrun
      if (done && slot_free) begin
        dout <= word;
        dout_valid <= 1'b1;
      end else begin
        if (dout_valid && bus.dout_ready) dout_valid <= 1'b0;
        if (done) overrun <= 1'b1;
      end
    end
  end
  assign bus.dout = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.sel_cnt = cnt;
  assign bus.frame_err = frame_err;
  assign bus.overrun = overrun;
endmodule

// File: tb/tb_demux1to16_deser.sv
// tb_demux1to16_deser: directed plus random stimulus against a bit-queue reference model
module tb_demux1to16_deser;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;
  bit q[$];
  logic [15:0] m_dout;
  logic m_valid, m_ferr, m_ovr;
  demux1to16_deser_if #(.WIDTH(16), .SEL_W(4)) bus ();
  demux1to16_deser #(.WIDTH(16), .SEL_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input bit d, input bit v, input bit s, input bit r, input bit rn);
    logic [15:0] w;
    bit done, xfer, free;
    bus.din = d;
    bus.din_valid = v;
    bus.sof = s;
    bus.dout_ready = r;
    rst_n = rn;
    w = '0;
    done = 0;
    if (!rn) begin
      q.delete();
      m_dout = '0;
      m_valid = 0;
      m_ferr = 0;
      m_ovr = 0;
    end else begin
      xfer = m_valid && r;
      free = !m_valid || r;
      m_ferr = v && s && (q.size() != 0);
      if (v) begin
        if (s) q.delete();
        q.push_back(d);
        if (!s && q.size() == 16) begin
          for (int k = 0; k < 16; k++) w = w | (16'(q[k]) << k);
          q.delete();
          done = 1;
        end
      end
      if (done && free) begin
        m_dout = w;
        m_valid = 1;
      end else begin
        if (xfer) m_valid = 0;
        if (done) m_ovr = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("dout_valid", bus.dout_valid, m_valid);
    chk("dout", bus.dout, m_dout);
    chk("sel_cnt", bus.sel_cnt, q.size());
    chk("frame_err", bus.frame_err, m_ferr);
    chk("overrun", bus.overrun, m_ovr);
  endtask
  task automatic send_word(input logic [15:0] w, input bit r);
    for (int i = 0; i < 16; i++) cycle(w[i], 1, i == 0, r, 1);
  endtask
  task automatic do_reset();
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
  endtask
  initial begin
    int ferrs;
    do_reset();
    chk("reset_dout", bus.dout, 16'h0);
    send_word(16'h30FA, 0);
    chk("w1_dout", bus.dout, 16'h30FA);
    chk("w1_valid", bus.dout_valid, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
    chk("w1_held", bus.dout, 16'h30FA);
    cycle(0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a5 = 16'hA5C3;
      cycle(a5[i], 1, i == 0, 1, 1);
      if (i < 15) cycle(0, 0, 0, 1, 1);
    end
    chk("toggle_dout", bus.dout, 16'hA5C3);
    chk("toggle_valid", bus.dout_valid, 1);
    cycle(0, 0, 0, 1, 1);
    chk("toggle_drop", bus.dout_valid, 0);
    ferrs = 0;
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 1, 1);
    for (int i = 0; i < 16; i++) begin
      cycle(i == 0, 1, i == 0, 1, 1);
      ferrs += bus.frame_err;
    end
    chk("ferr_once", ferrs, 1);
    chk("ferr_word", bus.dout, 16'h0001);
    do_reset();
    send_word(16'h1234, 0);
    send_word(16'hFFFF, 0);
    chk("ovr_dout", bus.dout, 16'h1234);
    chk("ovr_set", bus.overrun, 1);
    cycle(0, 0, 0, 1, 1);
    chk("ovr_drain", bus.dout_valid, 0);
    chk("ovr_sticky", bus.overrun, 1);
    do_reset();
    send_word(16'h1234, 0);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] be = 16'hBEEF;
      cycle(be[i], 1, i == 0, i == 15, 1);
    end
    chk("b2b_dout", bus.dout, 16'hBEEF);
    chk("b2b_ovr", bus.overrun, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, i == 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    chk("rst_cnt", bus.sel_cnt, 0);
    chk("rst_valid", bus.dout_valid, 0);
    send_word(16'h00FF, 0);
    chk("rst_word", bus.dout, 16'h00FF);
    do_reset();
    for (int i = 0; i < 4000; i++)
      cycle($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 299) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
